// File: rtl/wb_pkg.sv
// Shared constants and entry type for the register-file writeback queue.
package wb_pkg;

    localparam int unsigned WB_DEPTH = 4;
    localparam logic [4:0]  REG_ZERO = 5'd31;

    typedef struct packed {
        logic [4:0]  Reg;
        logic [63:0] Data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Circular buffer with up to two pushes and one pop per cycle; exposes the
// per-slot valid bits and destination registers for hazard matching.
module wbq_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push_a,
    input  logic [4:0]                   i_reg_a,
    input  logic [DATA_W-1:0]            i_data_a,
    input  logic                         i_push_b,
    input  logic [4:0]                   i_reg_b,
    input  logic [DATA_W-1:0]            i_data_b,
    input  logic                         i_pop,
    output logic [4:0]                   o_head_reg,
    output logic [DATA_W-1:0]            o_head_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [DEPTH-1:0]             o_valid,
    output logic [DEPTH-1:0][4:0]        o_regs
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [DEPTH-1:0]  r_valid;
    logic [4:0]        r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     w_wptr1;

    assign w_wptr1 = r_wptr + PW'(1);

    // Slot b is only ever used together with slot a, so it always lands at wptr+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PW'(1);
            end
            if (i_push_a) r_valid[r_wptr]  <= 1'b1;
            if (i_push_b) r_valid[w_wptr1] <= 1'b1;
            r_wptr  <= r_wptr + PW'(i_push_a) + PW'(i_push_b);
            r_count <= r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push_a) begin
            r_reg[r_wptr]  <= i_reg_a;
            r_data[r_wptr] <= i_data_a;
        end
        if (i_push_b) begin
            r_reg[w_wptr1]  <= i_reg_b;
            r_data[w_wptr1] <= i_data_b;
        end
    end

    always_comb begin
        o_regs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_regs[i] = r_reg[i];
        end
    end

    assign o_head_reg  = r_reg[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_count     = r_count;
    assign o_valid     = r_valid;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register-file write initiator: merges ALU and load writebacks in order,
// drops writes to register 31, drains one entry per cycle, flags pending regs.
module regfile_writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemValid,
    input  logic [4:0]                 MemReg,
    input  logic [DATA_W-1:0]          MemData,
    output logic                       MemReady,
    input  logic                       AluValid,
    input  logic [4:0]                 AluReg,
    input  logic [DATA_W-1:0]          AluData,
    output logic                       AluReady,
    input  logic                       WriteHold,
    output logic                       RegWrite,
    output logic [4:0]                 WriteRegister,
    output logic [DATA_W-1:0]          WriteData,
    input  logic [4:0]                 QueryReg1,
    input  logic [4:0]                 QueryReg2,
    output logic                       Pending1,
    output logic                       Pending2,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic                 w_mem_enq;
    logic                 w_alu_enq;
    logic                 w_push_a;
    logic [4:0]           w_reg_a;
    logic [DATA_W-1:0]    w_data_a;
    logic                 w_push_b;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [4:0]           w_head_reg;
    logic [DATA_W-1:0]    w_head_data;
    logic [CW-1:0]        w_count;
    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0][4:0] w_regs;
    logic                 w_hit1;
    logic                 w_hit2;

    // Ready looks only at the registered occupancy, never at this cycle's pop.
    assign MemReady = (w_count < CW'(DEPTH));
    assign AluReady = MemValid ? (w_count < CW'(DEPTH - 1)) : (w_count < CW'(DEPTH));

    assign w_mem_enq = MemValid && MemReady && (MemReg != REG_ZERO);
    assign w_alu_enq = AluValid && AluReady && (AluReg != REG_ZERO);

    // Compact surviving requests so the older load always takes the first slot.
    assign w_push_a = w_mem_enq || w_alu_enq;
    assign w_reg_a  = w_mem_enq ? MemReg  : AluReg;
    assign w_data_a = w_mem_enq ? MemData : AluData;
    assign w_push_b = w_mem_enq && w_alu_enq;

    assign w_nonempty = (w_count != '0) && !reset;
    assign w_pop      = w_nonempty && !WriteHold;

    wbq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push_a    (w_push_a),
        .i_reg_a     (w_reg_a),
        .i_data_a    (w_data_a),
        .i_push_b    (w_push_b),
        .i_reg_b     (AluReg),
        .i_data_b    (AluData),
        .i_pop       (w_pop),
        .o_head_reg  (w_head_reg),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_regs      (w_regs)
    );

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_regs[i] == QueryReg1)) w_hit1 = 1'b1;
            if (w_valid[i] && (w_regs[i] == QueryReg2)) w_hit2 = 1'b1;
        end
    end

    assign Pending1 = w_hit1 && (QueryReg1 != REG_ZERO) && !reset;
    assign Pending2 = w_hit2 && (QueryReg2 != REG_ZERO) && !reset;

    assign RegWrite      = w_pop;
    assign WriteRegister = w_nonempty ? w_head_reg  : '0;
    assign WriteData     = w_nonempty ? w_head_data : '0;
    assign Count         = w_count;

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Initiator side of the 32x64 register file write port.
- Accepts writeback requests from two pipeline sources: the ALU result path and the memory-load path.
- Buffers them in order in a small FIFO and drives the register file's RegWrite/WriteRegister/WriteData one entry per cycle.
- Also reports whether a register has a write still queued, so hazard logic can stall readers.

Parameters:
- DEPTH, 4, number of buffered writeback entries (power of two, >= 2).
- DATA_W, 64, writeback data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemValid  input  1  memory-load writeback request valid.
- MemReg  input  5  destination register for the memory request.
- MemData  input  DATA_W  load data.
- MemReady  output  1  queue accepts the memory request this cycle.
- AluValid  input  1  ALU writeback request valid.
- AluReg  input  5  destination register for the ALU request.
- AluData  input  DATA_W  ALU result.
- AluReady  output  1  queue accepts the ALU request this cycle.
- WriteHold  input  1  when 1, suppress draining this cycle.
- RegWrite  output  1  write enable to the register file.
- WriteRegister  output  5  register-file write address.
- WriteData  output  DATA_W  register-file write data.
- QueryReg1  input  5  register number checked for a pending write.
- QueryReg2  input  5  second query register.
- Pending1  output  1  a queued entry targets QueryReg1.
- Pending2  output  1  a queued entry targets QueryReg2.
- Count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Handshake: a transfer occurs on a rising edge when Valid && Ready for that source. Valid/Reg/Data must hold until accepted.
- Ready is derived only from the registered Count, never from this cycle's drain, so there is no combinational path from WriteHold to Ready.
  - free = DEPTH - Count.
  - MemReady = (free >= 1).
  - AluReady = (free >= 1 + MemValid).
- Ordering: if both sources transfer in the same cycle, the Mem entry is enqueued ahead of the Alu entry (the load is older in program order).
- Register 31:
  - A request with Reg == 31 still completes its handshake (Ready is computed as above).
  - The entry is discarded: it does not occupy a slot and is never issued.
- Drain:
  - RegWrite = (Count != 0) && !WriteHold.
  - WriteRegister/WriteData = head entry when Count != 0, else 0.
  - The head is popped on the same edge where RegWrite = 1.
  - Maximum one pop per cycle.
- Latency: a request accepted at edge N is visible on the write port after edge N (if the queue was empty) and is written into the register file at edge N+1.
- Count update: Count_next = Count + enq_mem + enq_alu - pop, where enq_* excludes Reg == 31 drops. Count never exceeds DEPTH.
- Full (Count == DEPTH): both Ready = 0, even if a pop occurs in the same cycle.
- Empty: RegWrite = 0, WriteRegister = 0, WriteData = 0. WriteHold has no effect.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The two-entry enqueue writes slots wptr and wptr+1 (mod DEPTH).
- Pending:
  - PendingK = 1 if any occupied entry, including the head being drained this cycle, has Reg == QueryRegK.
  - QueryRegK == 31 always gives 0.
  - Requests being accepted this cycle are not included.
- Duplicates: two entries with the same Reg are legal. They are issued in FIFO order, so the last write wins in the register file.
- Reset:
  - Count = 0, pointers = 0, RegWrite = 0, WriteRegister = 0, WriteData = 0, Pending1/2 = 0.
  - MemReady = AluReady = 1 while the queue is empty.
  - Reset during operation discards all queued entries; nothing is issued on the reset edge or the cycle after.

Decomposition:
- Package wb_pkg holds:
  - WB_DEPTH = 4.
  - REG_ZERO = 5'd31.
  - typedef struct packed { logic [4:0] Reg; logic [63:0] Data; } wb_entry_t.
- Sub-module wbq_fifo: a circular buffer with dual-push, single-pop, and a per-entry valid vector feeding the Pending match.
- The top level holds the handshake, R31 filter and drain/port muxing.

Test Plan:
- Single write: reset, then AluValid = 1, AluReg = 5, AluData = 64'hA0 for one cycle. Expect next cycle RegWrite = 1, WriteRegister = 5, WriteData = 64'hA0, Pending1 = 1 with QueryReg1 = 5. One cycle later Count = 0 and RegWrite = 0.
- Dual enqueue ordering: Mem (reg 3, 64'h11) and Alu (reg 3, 64'h22) in the same cycle. Expect issue of 64'h11 then 64'h22 on consecutive cycles; the register file reads reg 3 = 64'h22.
- R31 drop: AluReg = 31, AluData = 64'hFF accepted. Expect Count unchanged, RegWrite never asserted, Pending1 = 0 with QueryReg1 = 31.
- Full/backpressure:
  - WriteHold = 1; enqueue 4 entries (regs 1..4). Expect Count = 4 and MemReady = AluReady = 0.
  - At Count = 3 with MemValid = 1, expect AluReady = 0.
  - Release WriteHold; expect regs 1, 2, 3, 4 issued in order, wrapping the pointers.
- Wrap-around: stream 10 alternating Mem/Alu writes with regs i and data i*64'h0000010204080001. Read back all registers through the register file and match.
- Reset mid-operation: with 3 entries queued, assert reset for one cycle. Expect Count = 0, RegWrite = 0 and Pending = 0. The targeted registers keep their prior values.
